// File: rtl/data_bus_streamer.sv
// Snapshot the data-memory bus on a start pulse and stream it out byte-by-byte over valid/ready.
// Optional trailing XOR checksum byte: define DATA_BUS_STREAMER_CHECKSUM_EN.
module data_bus_streamer #(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_CAPACITY = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_Dump_Start,
  input  logic [DATA_WIDTH*DATA_CAPACITY-1:0]   i_Data_Bus,
  input  logic                                  i_Byte_Ready,
  output logic [7:0]                            o_Byte_Data,
  output logic                                  o_Byte_Valid,
  output logic                                  o_Busy,
  output logic [$clog2(DATA_CAPACITY)-1:0]      o_Word_Index,
  output logic                                  o_Done
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned TOTAL = BYTES * DATA_CAPACITY;
  localparam int unsigned BW    = $clog2(BYTES);
  localparam int unsigned WW    = $clog2(DATA_CAPACITY);
  localparam int unsigned IW    = $clog2(TOTAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TOTAL-1:0][7:0]  shadow_q, shadow_d;
  logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [WW-1:0]          word_cnt_q, word_cnt_d;
  logic [7:0]             byte_data_q, byte_data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic                   xfer;
  logic                   last_byte;
  logic [BW-1:0]          byte_nxt;
  logic [WW-1:0]          word_nxt;
  logic [IW-1:0]          next_idx;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    byte_data_d = byte_data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    xfer      = valid_q && i_Byte_Ready;
    last_byte = (word_cnt_q == WW'(DATA_CAPACITY - 1)) && (byte_cnt_q == BW'(BYTES - 1));
    if (byte_cnt_q == BW'(BYTES - 1)) begin
      byte_nxt = '0;
      word_nxt = word_cnt_q + WW'(1);
    end else begin
      byte_nxt = byte_cnt_q + BW'(1);
      word_nxt = word_cnt_q;
    end
    // Packed byte array layout makes word k, byte j sit at flat index k*BYTES+j.
    next_idx = IW'(word_nxt) * IW'(BYTES) + IW'(byte_nxt);

    case (state_q)
      S_IDLE: begin
        if (i_Dump_Start) begin
          shadow_d    = i_Data_Bus;
          byte_data_d = i_Data_Bus[7:0];
          byte_cnt_d  = '0;
          word_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        valid_d = 1'b1;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data_q;
`endif
          if (last_byte) begin
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
            byte_data_d = csum_q ^ byte_data_q;
            state_d     = S_CSUM;
`else
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
            byte_cnt_d  = byte_nxt;
            word_cnt_d  = word_nxt;
            byte_data_d = shadow_q[next_idx];
          end
        end
      end
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        byte_cnt_d  = '0;
        word_cnt_d  = '0;
        byte_data_d = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      byte_data_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      byte_data_q <= byte_data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign o_Byte_Data  = byte_data_q;
  assign o_Byte_Valid = valid_q;
  assign o_Busy       = busy_q;
  assign o_Word_Index = word_cnt_q;
  assign o_Done       = done_q;

endmodule

// File: tb/tb_data_bus_streamer.sv
// Directed and randomized dumps of data_bus_streamer checked against a byte-list model of the snapshot.
module tb_data_bus_streamer;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int B  = W / 8;
  localparam int NB = N * B;
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
  localparam int EXP_DONE = NB + 3;
`else
  localparam int EXP_DONE = NB + 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           i_Dump_Start;
  logic [W*N-1:0] i_Data_Bus;
  logic           i_Byte_Ready;
  logic [7:0]     o_Byte_Data;
  logic           o_Byte_Valid;
  logic           o_Busy;
  logic [3:0]     o_Word_Index;
  logic           o_Done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  data_bus_streamer #(.DATA_WIDTH(W), .DATA_CAPACITY(N)) dut (
    .clk(clk), .reset(reset), .i_Dump_Start(i_Dump_Start), .i_Data_Bus(i_Data_Bus),
    .i_Byte_Ready(i_Byte_Ready), .o_Byte_Data(o_Byte_Data), .o_Byte_Valid(o_Byte_Valid),
    .o_Busy(o_Busy), .o_Word_Index(o_Word_Index), .o_Done(o_Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void build_exp(input logic [W*N-1:0] bus);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      b = 8'(bus >> (8 * i));
      x = x ^ b;
      exp_q.push_back(b);
    end
`ifdef DATA_BUS_STREAMER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic set_pattern();
    for (int k = 0; k < N; k++) i_Data_Bus[k*W +: W] = 32'h0403_0201 + 32'(k) * 32'h0404_0404;
  endtask

  // ready_mode: 0 high, 1 toggling, 2 random. Negative *_at arguments disable that event.
  task automatic dump(input int ready_mode, input int stall_at, input int poke_at,
                      input int reset_at, input int start_cycles, input bit start_in_done,
                      input int exp_done_n, input string tag);
    logic [7:0] pd;
    logic [3:0] pi;
    logic       pv, pr;
    int done_n, done_cnt, stall_left, widx;
    bit stalled, poked;
    build_exp(i_Data_Bus);
    got_q.delete();
    done_n = -1; done_cnt = 0; stall_left = 0; stalled = 0; poked = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
    @(negedge clk);
    i_Dump_Start = 1'b1;
    i_Byte_Ready = (ready_mode == 0);
    for (int n = 1; n < 400; n++) begin
      @(negedge clk);
      i_Dump_Start = (n < start_cycles);
      if (n == 1) begin
        check({tag, "/load_busy"}, 32'(o_Busy), 1);
        check({tag, "/load_valid"}, 32'(o_Byte_Valid), 0);
      end
      if (n == 2) begin
        check({tag, "/first_valid"}, 32'(o_Byte_Valid), 1);
        check({tag, "/first_byte"}, 32'(o_Byte_Data), 32'(exp_q[0]));
      end
      if (pv && !pr && done_n < 0) begin
        check({tag, "/hold_data"}, 32'(o_Byte_Data), 32'(pd));
        check({tag, "/hold_index"}, 32'(o_Word_Index), 32'(pi));
        check({tag, "/hold_valid"}, 32'(o_Byte_Valid), 1);
      end
      if (reset_at >= 0 && got_q.size() == reset_at) begin
        i_Byte_Ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "/rst_data"}, 32'(o_Byte_Data), 0);
        check({tag, "/rst_valid"}, 32'(o_Byte_Valid), 0);
        check({tag, "/rst_busy"}, 32'(o_Busy), 0);
        check({tag, "/rst_index"}, 32'(o_Word_Index), 0);
        check({tag, "/rst_done"}, 32'(o_Done), 0);
        @(negedge clk);
        check({tag, "/rst_idle"}, 32'(o_Busy), 0);
        return;
      end
      if (o_Done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n;
          check({tag, "/done_busy"}, 32'(o_Busy), 0);
          check({tag, "/done_valid"}, 32'(o_Byte_Valid), 0);
          check({tag, "/done_index"}, 32'(o_Word_Index), N - 1);
          if (start_in_done) i_Dump_Start = 1'b1;
        end
      end
      if (done_n >= 0 && n == done_n + 1) begin
        check({tag, "/idle_busy"}, 32'(o_Busy), 0);
        check({tag, "/idle_index"}, 32'(o_Word_Index), 0);
        check({tag, "/idle_done"}, 32'(o_Done), 0);
      end
      if (done_n >= 0 && n == done_n + 2) begin
        check({tag, "/idle_busy2"}, 32'(o_Busy), 0);
        break;
      end
      if (poke_at >= 0 && !poked && got_q.size() == poke_at) begin
        poked = 1;
        i_Data_Bus = '1;
        i_Dump_Start = 1'b1;
      end
      if (stall_at >= 0 && !stalled && got_q.size() == stall_at) begin
        stalled = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        i_Byte_Ready = 1'b0;
        stall_left--;
      end else if (ready_mode == 0) i_Byte_Ready = 1'b1;
      else if (ready_mode == 1) i_Byte_Ready = (n % 2 == 0);
      else i_Byte_Ready = 1'($urandom_range(0, 1));
      if (o_Byte_Valid && i_Byte_Ready) begin
        widx = got_q.size() / B;
        if (widx > N - 1) widx = N - 1;
        check({tag, "/word_index"}, 32'(o_Word_Index), widx);
        if (stall_at == 17 && got_q.size() == 17) check({tag, "/index_at_17"}, 32'(o_Word_Index), 4);
        got_q.push_back(o_Byte_Data);
      end
      pv = o_Byte_Valid; pr = i_Byte_Ready; pd = o_Byte_Data; pi = o_Word_Index;
    end
    i_Dump_Start = 1'b0;
    check({tag, "/done_count"}, done_cnt, 1);
    if (exp_done_n > 0) check({tag, "/done_latency"}, done_n, exp_done_n);
    check({tag, "/length"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s/byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset = 1'b1; i_Dump_Start = 1'b0; i_Byte_Ready = 1'b0; i_Data_Bus = '0;
    repeat (2) @(negedge clk);
    check("reset/data", 32'(o_Byte_Data), 0);
    check("reset/valid", 32'(o_Byte_Valid), 0);
    check("reset/busy", 32'(o_Busy), 0);
    check("reset/index", 32'(o_Word_Index), 0);
    check("reset/done", 32'(o_Done), 0);
    reset = 1'b0;
    @(negedge clk);

    set_pattern();
    dump(0, -1, -1, -1, 1, 0, EXP_DONE, "t1");
    dump(1, 17, -1, -1, 1, 0, -1, "t2");
    dump(0, -1, 10, -1, 1, 1, EXP_DONE, "t3");
    set_pattern();
    dump(0, -1, -1, 30, 1, 0, -1, "t4");
    dump(0, -1, -1, -1, 1, 0, EXP_DONE, "t4fresh");
    i_Data_Bus = '0;
    dump(0, -1, -1, -1, 3, 1, EXP_DONE, "t6");
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) i_Data_Bus[k*W +: W] = $urandom;
      dump(2, -1, -1, -1, 1, 0, -1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
